// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: DEPTH-entry FIFO followed by a registered decode-facing slot.
// Define IFQ_BYPASS_EN to let an accepted instruction skip the empty FIFO (1-cycle latency).
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  inst_i,
  input  logic [31:0]                  inst_addr_i,
  input  logic                         inst_valid_i,
  output logic                         inst_ready_o,
  input  logic                         hold_i,
  input  logic                         flush_i,
  output logic [31:0]                  inst_o,
  output logic [31:0]                  inst_addr_o,
  output logic                         inst_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem_inst_r [DEPTH];
  logic [31:0]   mem_addr_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic accept_s;
  logic push_s;
  logic pop_s;
  logic bypass_s;

  assign inst_ready_o = (count_r < DEPTH_C);
  assign count_o      = count_r;

  // A flush drops the same-cycle input even though ready may be high.
  assign accept_s = inst_valid_i & inst_ready_o & ~flush_i;
  assign pop_s    = ~hold_i & ~flush_i & (count_r != {CW{1'b0}});

`ifdef IFQ_BYPASS_EN
  assign bypass_s = accept_s & ~hold_i & (count_r == {CW{1'b0}});
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s = accept_s & ~bypass_s;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // FIFO storage write port; contents are don't-care until referenced by count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_inst_r[wr_ptr_r] <= inst_i;
      mem_addr_r[wr_ptr_r] <= inst_addr_i;
    end
  end

  // Decode-facing output register: FIFO head takes priority over bypass to keep ordering.
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= 32'h00000000;
      inst_valid_o <= 1'b0;
    end else if (!hold_i) begin
      if (pop_s) begin
        inst_o       <= mem_inst_r[rd_ptr_r];
        inst_addr_o  <= mem_addr_r[rd_ptr_r];
        inst_valid_o <= 1'b1;
      end else if (bypass_s) begin
        inst_o       <= inst_i;
        inst_addr_o  <= inst_addr_i;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_addr_o  <= 32'h00000000;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a queue-based scoreboard tracks accepted
// instructions and the expected decode slot, compared after every clock edge.
module tb_if_id_queue;

  localparam int          DEPTH     = 2;
  localparam logic [31:0] NOP_INST  = 32'h00000001;
  localparam logic [31:0] INST_BASE = 32'hC0DE0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        hold_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  ent_t        sb_q[$];
  logic [31:0] m_inst  = NOP_INST;
  logic [31:0] m_addr  = 32'h0;
  logic        m_valid = 1'b0;
  bit          known   = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: model the expected next state, then compare after the edge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] a,
                       input logic h, input logic f, output logic acc);
    ent_t e;
    rst          = r;
    inst_valid_i = v;
    inst_addr_i  = a;
    inst_i       = INST_BASE | a;
    hold_i       = h;
    flush_i      = f;
    #1;
    if (known) chk("ready", 32'(inst_ready_o), 32'(sb_q.size() < DEPTH));
    acc    = r && v && !f && (sb_q.size() < DEPTH);
    e.inst = INST_BASE | a;
    e.addr = a;
    if (!r || f) begin
      sb_q.delete();
      m_inst = NOP_INST; m_addr = 32'h0; m_valid = 1'b0;
    end else if (!h) begin
      if (sb_q.size() > 0) begin
        ent_t hd;
        hd = sb_q.pop_front();
        m_inst = hd.inst; m_addr = hd.addr; m_valid = 1'b1;
        if (acc) sb_q.push_back(e);
      end else if (acc && BYP) begin
        m_inst = e.inst; m_addr = e.addr; m_valid = 1'b1;
      end else begin
        if (acc) sb_q.push_back(e);
        m_inst = NOP_INST; m_addr = 32'h0; m_valid = 1'b0;
      end
    end else begin
      if (acc) sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    known = 1'b1;
    chk("valid", 32'(inst_valid_o), 32'(m_valid));
    chk("addr",  inst_addr_o, m_addr);
    chk("inst",  inst_o, m_inst);
    chk("count", 32'(count_o), 32'(sb_q.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic acc;
    int   idx;
    rst = 1'b0; inst_valid_i = 1'b0; inst_addr_i = 32'h0; inst_i = 32'h0;
    hold_i = 1'b0; flush_i = 1'b0;

    // Reset held two cycles with valid input present.
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, acc);
    cycle(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, acc);
    chk("reset_inst", inst_o, 32'h00000001);
    chk("reset_count", 32'(count_o), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Back-to-back streaming.
    cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, acc);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Fill under hold; third push must be refused.
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, acc);
    chk("full_ready", 32'(inst_ready_o), 32'd0);
    cycle(1'b1, 1'b1, 32'h18, 1'b1, 1'b0, acc);
    chk("full_reject", 32'(acc), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Flush dominates hold and drops the same-cycle input.
    cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h24, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h28, 1'b1, 1'b1, acc);
    chk("flush_count", 32'(count_o), 32'd0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Pointer wrap with alternating hold; rejected fetches are re-presented.
    idx = 0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      cycle(1'b1, 1'b1, 32'h100 + 32'(idx * 4), 1'(c % 2), 1'b0, acc);
      if (acc) idx++;
    end
    chk("wrap_accepted", 32'(idx), 32'd10);
    repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Simultaneous push and pop at count 1.
    cycle(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'h204, 1'b0, 1'b0, acc);
    chk("pushpop_count", 32'(count_o), 32'd1);
    chk("pushpop_head", inst_addr_o, 32'h200);
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // Reset mid-operation discards buffered entries.
    cycle(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, acc);
    cycle(1'b0, 1'b1, 32'h304, 1'b1, 1'b1, acc);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
